neureka_tcdm_responder: RTL and testbench



---
 rtl/neureka_tcdm_responder.sv | 111 +++++++++++
 tb/tb_neureka_tcdm_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/neureka_tcdm_responder.sv
// neureka_tcdm_responder: wide single-port SRAM target with fixed-latency, in-order, credit-throttled responses
// Ports: clk_i/rst_i clock and sync active-high reset; stall_i forces gnt low for contention injection;
// tcdm_* is the hci_core target port flattened (request req/gnt/add/wen/be/data/user/id, response
// r_valid/r_ready/r_data/r_user/r_id/r_opc, egnt/r_evalid tied off); outstanding_o is the credit count.
module neureka_tcdm_responder #(
  parameter int DW        = 256,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 4,
  parameter int AW        = 32,
  parameter int UW        = 1,
  parameter int IW        = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  logic                             tcdm_req,
  output logic                             tcdm_gnt,
  input  logic [AW-1:0]                    tcdm_add,
  input  logic                             tcdm_wen,
  input  logic [DW/8-1:0]                  tcdm_be,
  input  logic [DW-1:0]                    tcdm_data,
  input  logic [UW-1:0]                    tcdm_user,
  input  logic [IW-1:0]                    tcdm_id,
  output logic                             tcdm_egnt,
  output logic                             tcdm_r_valid,
  input  logic                             tcdm_r_ready,
  output logic [DW-1:0]                    tcdm_r_data,
  output logic [UW-1:0]                    tcdm_r_user,
  output logic [IW-1:0]                    tcdm_r_id,
  output logic                             tcdm_r_opc,
  output logic                             tcdm_r_evalid,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   outstanding_o
);
  localparam int OFF = $clog2(DW/8);
  localparam int XW  = $clog2(DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH+1);
  localparam int PW  = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } rsp_t;
  logic [DW-1:0] mem [DEPTH];
  rsp_t          fifo [RSP_DEPTH];
  rsp_t          s, push_d, head, last;
  logic [CW-1:0] cnt, fcnt;
  logic [PW-1:0] wp, rp;
  logic [XW-1:0] idx;
  logic          acc, push_v, pop, unused_add;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RSP_DEPTH-1) ? '0 : p + PW'(1);
  endfunction
  // byte offset and address bits above the array wrap away
  assign unused_add = ^tcdm_add;
  assign idx        = tcdm_add[OFF +: XW];
  assign tcdm_gnt   = tcdm_req & ~stall_i & ~rst_i & (cnt < CW'(RSP_DEPTH));
  assign acc        = tcdm_req & tcdm_gnt;
  assign s          = '{id: tcdm_id, user: tcdm_user, data: tcdm_wen ? mem[idx] : '0};
  // LATENCY-1 delay stages; the FIFO write supplies the last cycle of latency
  if (LATENCY == 1) begin : g_direct
    assign push_v = acc;
    assign push_d = s;
  end else begin : g_pipe
    logic [LATENCY-2:0] sh_v;
    rsp_t [LATENCY-2:0] sh_d;
    always_ff @(posedge clk_i) begin
      sh_v[0] <= ~rst_i & acc;
      sh_d[0] <= s;
      for (int k = 1; k < LATENCY-1; k++) begin
        sh_v[k] <= ~rst_i & sh_v[k-1];
        sh_d[k] <= sh_d[k-1];
      end
    end
    assign push_v = sh_v[LATENCY-2];
    assign push_d = sh_d[LATENCY-2];
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DW/8; i++)
      if (acc & ~tcdm_wen & tcdm_be[i]) mem[idx][i*8 +: 8] <= tcdm_data[i*8 +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (push_v) fifo[wp] <= push_d;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt  <= '0;
      fcnt <= '0;
      wp   <= '0;
      rp   <= '0;
      last <= '0;
    end else begin
      cnt  <= cnt + CW'(acc) - CW'(pop);
      fcnt <= fcnt + CW'(push_v) - CW'(pop);
      wp   <= push_v ? nxt(wp) : wp;
      rp   <= pop ? nxt(rp) : rp;
      last <= pop ? head : last;
    end
  end
  // when empty the outputs keep showing the last popped response
  assign head          = fifo[rp];
  assign tcdm_r_valid  = fcnt != '0;
  assign pop           = tcdm_r_valid & tcdm_r_ready;
  assign tcdm_r_data   = tcdm_r_valid ? head.data : last.data;
  assign tcdm_r_id     = tcdm_r_valid ? head.id : last.id;
  assign tcdm_r_user   = tcdm_r_valid ? head.user : last.user;
  assign tcdm_r_opc    = 1'b0;
  assign tcdm_egnt     = 1'b0;
  assign tcdm_r_evalid = 1'b0;
  assign outstanding_o = cnt;
endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// tb_neureka_tcdm_responder: directed stimulus with a queue scoreboard and a decoupled response monitor
module tb_neureka_tcdm_responder;
  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int RD    = 4;
  localparam logic [63:0] PA5 = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] P08 = 64'h0808_0808_0808_0808;
  localparam logic [63:0] PBB = 64'h0123_4567_0000_0000;
  typedef struct {
    logic [63:0] d;
    logic [7:0]  id;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, last_wait = 0;
  logic clk = 0, rst = 1, stall = 0, req = 0, wen = 1, r_ready = 1;
  logic [31:0] add = '0;
  logic [7:0]  be = '1;
  logic [63:0] wdata = '0;
  logic [3:0]  user = '0;
  logic [7:0]  id = '0;
  logic gnt, egnt, r_valid, r_opc, r_evalid;
  logic [63:0] r_data;
  logic [3:0]  r_user;
  logic [7:0]  r_id;
  logic [2:0]  outstanding;
  neureka_tcdm_responder #(
    .DW(DW), .DEPTH(DEPTH), .LATENCY(LAT), .RSP_DEPTH(RD), .AW(32), .UW(4), .IW(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be),
    .tcdm_data(wdata), .tcdm_user(user), .tcdm_id(id), .tcdm_egnt(egnt),
    .tcdm_r_valid(r_valid), .tcdm_r_ready(r_ready), .tcdm_r_data(r_data),
    .tcdm_r_user(r_user), .tcdm_r_id(r_id), .tcdm_r_opc(r_opc), .tcdm_r_evalid(r_evalid),
    .outstanding_o(outstanding)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && r_valid && r_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stale_rsp: got response id %0d, expected none", r_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", r_data, e.d);
        chk("rsp_id", 64'(r_id), 64'(e.id));
        chk("rsp_user", 64'(r_user), 64'(e.id[3:0]));
        chk("rsp_opc", 64'(r_opc), 64'd0);
        if (e.cyc >= 0) chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end
  task automatic req_op(input logic w, input logic [31:0] a, input logic [7:0] b,
                        input logic [63:0] d, input logic [7:0] i, input logic [63:0] e, input bit exact);
    int n = 0;
    req = 1; wen = w; add = a; be = b; wdata = d; id = i; user = i[3:0];
    @(negedge clk);
    while (!gnt && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!gnt) chk("gnt_timeout", 64'(gnt), 64'd1);
    else sb.push_back('{e, i, exact ? cyc + LAT : -1});
    last_wait = n;
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n = 0;
    req = 0; r_ready = 1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int g, gs, rv;
    req = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(r_valid), 64'd0);
    chk("rst_rdata", r_data, 64'd0);
    chk("rst_rid", 64'(r_id), 64'd0);
    chk("rst_ruser", 64'(r_user), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("ecc_tieoff", 64'({egnt, r_evalid}), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    req_op(0, 32'd40, 8'hFF, PA5, 8'd1, 64'd0, 1);
    chk("first_after_rst_wait", 64'(last_wait), 64'd0);
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd2, PA5, 1);
    req_op(0, 32'd56, 8'hFF, '1, 8'd3, 64'd0, 1);
    req_op(0, 32'd56, 8'h01, 64'd0, 8'd4, 64'd0, 1);
    req_op(1, 32'd56, 8'hFF, 64'd0, 8'd5, 64'hFFFF_FFFF_FFFF_FF00, 1);
    drain();
    r_ready = 0; req = 1; wen = 1; add = 32'd40; g = 0;
    for (int k = 0; k < 8; k++) begin
      id = 8'(10 + g); user = id[3:0];
      @(negedge clk);
      if (gnt) begin
        sb.push_back('{PA5, id, -1});
        g++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("fill_grants", 64'(g), 64'd4);
    chk("fill_outstanding", 64'(outstanding), 64'd4);
    chk("fill_gnt", 64'(gnt), 64'd0);
    chk("fill_rvalid_held", 64'(r_valid), 64'd1);
    chk("fill_rid_held", 64'(r_id), 64'd10);
    @(posedge clk); #1;
    r_ready = 1; id = 8'd14; user = id[3:0];
    @(negedge clk);
    chk("gnt_in_pop_cycle", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gnt_after_pop", 64'(gnt), 64'd1);
    if (gnt) sb.push_back('{PA5, id, -1});
    @(posedge clk); #1;
    drain();
    r_ready = 0;
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd20, PA5, 0);
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd21, PA5, 0);
    id = 8'd22; user = id[3:0]; r_ready = 1;
    @(negedge clk);
    chk("simul_cnt_before", 64'(outstanding), 64'd2);
    chk("simul_gnt", 64'(gnt), 64'd1);
    if (gnt) sb.push_back('{PA5, id, -1});
    @(posedge clk); #1;
    req = 0; r_ready = 0;
    @(negedge clk);
    chk("simul_cnt_after", 64'(outstanding), 64'd2);
    drain();
    for (int i = 0; i < 16; i++)
      req_op(0, 32'((16 + i) * 8), 8'hFF, PBB | 64'(i), 8'(100 + i), 64'd0, 1);
    for (int i = 0; i < 16; i++)
      req_op(1, 32'((16 + i) * 8), 8'hFF, 64'd0, 8'(120 + i), PBB | 64'(i), 1);
    drain();
    req_op(0, 32'd64, 8'hFF, P08, 8'd50, 64'd0, 1);
    drain();
    stall = 1; req = 1; wen = 1; add = 32'(DEPTH * 8 + 8 * 8); id = 8'd51; user = id[3:0];
    gs = 0; rv = 0;
    repeat (3) begin
      @(negedge clk);
      gs += int'(gnt);
      rv += int'(r_valid);
      @(posedge clk); #1;
    end
    chk("stall_grants", 64'(gs), 64'd0);
    chk("stall_rvalid", 64'(rv), 64'd0);
    stall = 0;
    req_op(1, 32'(DEPTH * 8 + 8 * 8), 8'hFF, 64'd0, 8'd51, P08, 1);
    chk("stall_release_wait", 64'(last_wait), 64'd0);
    drain();
    @(negedge clk);
    chk("empty_rvalid", 64'(r_valid), 64'd0);
    chk("empty_rdata_hold", r_data, P08);
    chk("empty_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk); #1;
    r_ready = 0;
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd60, PA5, 0);
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd61, PA5, 0);
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd62, PA5, 0);
    rst = 1; req = 1;
    sb.delete();
    @(negedge clk);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rvalid", 64'(r_valid), 64'd0);
    chk("midrst_outstanding", 64'(outstanding), 64'd0);
    chk("midrst_rdata", r_data, 64'd0);
    @(posedge clk); #1;
    rst = 0; req = 0; r_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    req_op(1, 32'd40, 8'hFF, 64'd0, 8'd70, PA5, 1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
